fm_demod: RTL and testbench
===========================

// Module: fm_demod
// PURPOSE
//  FM discriminator; sits directly after the complex channel FIR. Reads filtered I/Q from the
//  FIR output FIFO, multiplies each sample by the conjugate of the previous one, takes qarctan
//  of the product (iterative divider), scales by GAIN and pushes one 32-bit sample downstream.
//  Fixed point is Q10 throughout; the team's C model is bit-exact golden.
// PARAMETERS
//  DATA_WIDTH  32   width of I, Q and output words (signed, Q10)
//  QBITS       10   quantization shift (QUANT = 1<<QBITS = 1024)
//  GAIN        758  demod gain, Q10 (ADC_RATE/(2*pi*MAX_DEV))
//  QUAD1       804  pi/4 in Q10
//  QUAD3       2412 3*pi/4 in Q10
// PORTS
//  clock       in   1   single clock, all state on rising edge
//  reset       in   1   asynchronous, active-low
//  real_in     in   32  I sample at head of input FIFO (first-word-fall-through)
//  imag_in     in   32  Q sample at head of input FIFO
//  in_empty    in   1   input FIFO empty
//  in_rd_en    out  1   pop input FIFO; only when !in_empty
//  dout        out  32  demodulated sample, signed Q10
//  out_full    in   1   output FIFO full
//  out_wr_en   out  1   push dout; only when !out_full
// BEHAVIOUR
//  Reset (reset==0): state=S_READ; prev_real=prev_imag=0; dout=0; in_rd_en=out_wr_en=0; divider cleared.
//  DEQ(v) = v/1024 truncated toward zero (NOT arithmetic shift); QNT(v) = v*1024.
//  All products 64-bit signed; DEQ results truncated to 32 bits.
//  S_READ: if !in_empty: in_rd_en=1 for one cycle, latch cur=(real_in,imag_in) -> S_MULT.
//  S_MULT (1 cyc): r = DEQ(prev_real*cur_real) - DEQ(-prev_imag*cur_imag)
//                  i = DEQ(prev_real*cur_imag) + DEQ(-prev_imag*cur_real)
//                  prev <= cur (updated here, even if later stalled) -> S_PREP.
//  S_PREP (1 cyc): abs_y = |i|+1; x=r. x>=0: num=QNT(x-abs_y), den=x+abs_y;
//                  x<0: num=QNT(x+abs_y), den=abs_y-x. den always >=1, no div-by-zero path -> S_DIV.
//  S_DIV: signed restoring divide, quotient truncated toward zero; exactly 32 cycles -> S_ANGLE.
//  S_ANGLE (1 cyc): angle = (x>=0 ? QUAD1 : QUAD3) - DEQ(QUAD1*q); if i<0 angle=-angle;
//                  dout <= DEQ(GAIN*angle) -> S_WRITE.
//  S_WRITE: if !out_full: out_wr_en=1 one cycle, -> S_READ; else hold dout, wait (no timeout).
//  Latency: pop -> push = 36 cycles minimum; throughput 1 sample / 37 cycles when unstalled.
//  in_rd_en and out_wr_en never asserted in same cycle; each is a single-cycle pulse per sample.
//  in_empty toggling outside S_READ is ignored; out_full only sampled in S_WRITE.
//  Reset mid-operation: in-flight sample discarded, no push; prev history cleared to 0.
//  First sample after reset sees prev=0 (r=i=0) and yields 1190, per C model.
// TESTING
//  T1 reset, push (1024,0),(1024,0) -> dout 0x000004A6 (1190), then 0x00000001; 2 pushes total.
//  T2 push (1024,0),(0,1024) -> 2nd output 1190 (0x000004A6); (1024,0),(0,-1024) -> 2nd -1190 (0xFFFFFB5A).
//  T3 push (1024,0),(-1024,0) -> 2nd output 2379 (0x0000094B) (x<0 / QUAD3 branch).
//  T4 hold out_full=1 for 100 cycles after T1 1st result -> out_wr_en stays 0, dout stable at 1190,
//     no further pops; release -> exactly one push next cycle, stream continues correct.
//  T5 random in_empty gaps + out_full backpressure on 100 samples of FIR output file -> 0 mismatches
//     vs golden demod file; in_rd_en never while in_empty, out_wr_en never while out_full.
//  T6 assert reset during S_DIV -> outputs 0 immediately, no push; next sample treated as first (1190 for (1024,0)).

Source files
------------

// File: rtl/fm_demod.sv
// FM discriminator: conj-multiply consecutive I/Q samples, qarctan via a
// 32-cycle restoring divider, scale by GAIN and emit one Q10 sample.
module fm_demod #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned QBITS      = 10,
  parameter int          GAIN       = 758,
  parameter int          QUAD1      = 804,
  parameter int          QUAD3      = 2412
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] real_in,
  input  logic signed [DATA_WIDTH-1:0] imag_in,
  input  logic                         in_empty,
  output logic                         in_rd_en,
  output logic signed [DATA_WIDTH-1:0] dout,
  input  logic                         out_full,
  output logic                         out_wr_en
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned PW = 2 * DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH);

  typedef logic signed [DW-1:0] word_t;
  typedef logic signed [PW-1:0] prod_t;

  typedef enum logic [2:0] {
    S_READ, S_MULT, S_PREP, S_DIV, S_ANGLE, S_WRITE
  } state_t;

  // Dequantize: divide by 2^QBITS truncating toward zero, keep low DW bits
  function automatic word_t deq(input prod_t p);
    prod_t mag;
    mag = p[PW-1] ? -p : p;
    mag = mag >> QBITS;
    return p[PW-1] ? -DW'(mag) : DW'(mag);
  endfunction

  // Full-width signed product
  function automatic prod_t mul(input word_t a, input word_t b);
    return PW'(a) * PW'(b);
  endfunction

  state_t            state_q, state_d;
  logic              run_q, run_d;
  word_t             cur_re_q, cur_re_d, cur_im_q, cur_im_d;
  word_t             prev_re_q, prev_re_d, prev_im_q, prev_im_d;
  word_t             r_q, r_d, i_q, i_d;
  logic [DW-1:0]     rem_q, rem_d, quo_q, quo_d, den_q, den_d;
  logic              neg_q, neg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  word_t             dout_q, dout_d;

  word_t             abs_y, num, den, q_s, angle;
  logic [DW:0]       trial;

  assign dout = dout_q;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_READ;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_READ:  if (run_q && !in_empty) state_d = S_MULT;
      S_MULT:  state_d = S_PREP;
      S_PREP:  state_d = S_DIV;
      S_DIV:   if (cnt_q == CW'(DW - 1)) state_d = S_ANGLE;
      S_ANGLE: state_d = S_WRITE;
      S_WRITE: if (!out_full) state_d = S_READ;
      default: state_d = S_READ;
    endcase
  end

  // FIFO handshakes: single-cycle pulses qualified by the FIFO flags
  always_comb begin
    in_rd_en  = 1'b0;
    out_wr_en = 1'b0;
    case (state_q)
      S_READ:  in_rd_en  = run_q & ~in_empty;
      S_WRITE: out_wr_en = ~out_full;
      default: ;
    endcase
  end

  // Datapath: conj multiply, divider setup, restoring divide, angle and gain
  always_comb begin
    run_d     = 1'b1;
    cur_re_d  = cur_re_q;
    cur_im_d  = cur_im_q;
    prev_re_d = prev_re_q;
    prev_im_d = prev_im_q;
    r_d       = r_q;
    i_d       = i_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    den_d     = den_q;
    neg_d     = neg_q;
    cnt_d     = cnt_q;
    dout_d    = dout_q;
    abs_y     = '0;
    num       = '0;
    den       = '0;
    q_s       = '0;
    angle     = '0;
    trial     = '0;
    case (state_q)
      S_READ: begin
        if (in_rd_en) begin
          cur_re_d = real_in;
          cur_im_d = imag_in;
        end
      end
      S_MULT: begin
        r_d       = deq(mul(prev_re_q, cur_re_q)) - deq(-mul(prev_im_q, cur_im_q));
        i_d       = deq(mul(prev_re_q, cur_im_q)) + deq(-mul(prev_im_q, cur_re_q));
        prev_re_d = cur_re_q;
        prev_im_d = cur_im_q;
      end
      S_PREP: begin
        abs_y = (i_q[DW-1] ? -i_q : i_q) + word_t'(1);
        if (!r_q[DW-1]) begin
          num = (r_q - abs_y) <<< QBITS;
          den = r_q + abs_y;
        end else begin
          num = (r_q + abs_y) <<< QBITS;
          den = abs_y - r_q;
        end
        // den is always positive, so the quotient sign is the numerator sign
        neg_d = num[DW-1];
        quo_d = num[DW-1] ? -num : num;
        den_d = den;
        rem_d = '0;
        cnt_d = '0;
      end
      S_DIV: begin
        trial = {rem_q, quo_q[DW-1]};
        if (trial >= {1'b0, den_q}) begin
          rem_d = DW'(trial - {1'b0, den_q});
          quo_d = {quo_q[DW-2:0], 1'b1};
        end else begin
          rem_d = trial[DW-1:0];
          quo_d = {quo_q[DW-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
      end
      S_ANGLE: begin
        q_s   = neg_q ? -word_t'(quo_q) : word_t'(quo_q);
        angle = (r_q[DW-1] ? word_t'(QUAD3) : word_t'(QUAD1))
              - deq(mul(word_t'(QUAD1), q_s));
        if (i_q[DW-1]) angle = -angle;
        dout_d = deq(mul(word_t'(GAIN), angle));
      end
      default: ;
    endcase
  end

  // Datapath registers; reset discards any in-flight sample and history
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_q     <= 1'b0;
      cur_re_q  <= '0;
      cur_im_q  <= '0;
      prev_re_q <= '0;
      prev_im_q <= '0;
      r_q       <= '0;
      i_q       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      den_q     <= '0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
      dout_q    <= '0;
    end else begin
      run_q     <= run_d;
      cur_re_q  <= cur_re_d;
      cur_im_q  <= cur_im_d;
      prev_re_q <= prev_re_d;
      prev_im_q <= prev_im_d;
      r_q       <= r_d;
      i_q       <= i_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      den_q     <= den_d;
      neg_q     <= neg_d;
      cnt_q     <= cnt_d;
      dout_q    <= dout_d;
    end
  end

endmodule

// File: tb/tb_fm_demod.sv
// Self-checking bench for fm_demod: FIFO models on both sides, arithmetic
// reference model, directed cases plus a randomized backpressure run.
module tb_fm_demod;

  logic               clock;
  logic               reset;
  logic signed [31:0] real_in;
  logic signed [31:0] imag_in;
  logic               in_empty;
  logic               in_rd_en;
  logic signed [31:0] dout;
  logic               out_full;
  logic               out_wr_en;

  fm_demod dut (
    .clock     (clock),
    .reset     (reset),
    .real_in   (real_in),
    .imag_in   (imag_in),
    .in_empty  (in_empty),
    .in_rd_en  (in_rd_en),
    .dout      (dout),
    .out_full  (out_full),
    .out_wr_en (out_wr_en)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct { int re; int im; } samp_t;

  samp_t in_q[$];
  int    exp_q[$];
  int    got_q[$];
  int    lat_q[$];
  int    pend_q[$];
  int    popc_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    prv_re = 0;
  int    prv_im = 0;
  bit    gap_mode = 1'b0;
  int    full_mode = 0;
  logic  s_rd, s_wr;

  // Reference: v/1024 truncated toward zero
  function automatic int ref_deq(input longint v);
    return int'(v / 64'sd1024);
  endfunction

  // Reference discriminator for one (prev, cur) pair
  function automatic int ref_demod(input int pr, input int pim, input int cr, input int ci);
    int r, i, ay, num, den, q, ang;
    r  = ref_deq(longint'(pr) * ci * 0 + longint'(pr) * cr) - ref_deq(-longint'(pim) * ci);
    i  = ref_deq(longint'(pr) * ci) + ref_deq(-longint'(pim) * cr);
    ay = ((i < 0) ? -i : i) + 1;
    if (r >= 0) begin
      num = (r - ay) * 1024;
      den = r + ay;
    end else begin
      num = (r + ay) * 1024;
      den = ay - r;
    end
    q   = num / den;
    ang = ((r >= 0) ? 804 : 2412) - ref_deq(longint'(804) * q);
    if (i < 0) ang = -ang;
    return ref_deq(longint'(758) * ang);
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, want);
    end
  endtask

  // One clock: drive FIFO flags at negedge, sample handshakes, update models
  task automatic cycle();
    bit gap;
    @(negedge clock);
    gap      = gap_mode && ($urandom_range(0, 3) == 0);
    in_empty = (in_q.size() == 0) || gap;
    if (in_q.size() != 0) begin
      real_in = in_q[0].re;
      imag_in = in_q[0].im;
    end
    case (full_mode)
      0:       out_full = 1'b0;
      1:       out_full = 1'b1;
      default: out_full = ($urandom_range(0, 2) == 0);
    endcase
    #1;
    cyc++;
    s_rd = in_rd_en;
    s_wr = out_wr_en;
    chk("rd_while_empty", 64'(in_rd_en & in_empty), 0);
    chk("wr_while_full",  64'(out_wr_en & out_full), 0);
    chk("rd_and_wr",      64'(in_rd_en & out_wr_en), 0);
    if (in_rd_en && in_q.size() != 0) begin
      exp_q.push_back(ref_demod(prv_re, prv_im, in_q[0].re, in_q[0].im));
      prv_re = in_q[0].re;
      prv_im = in_q[0].im;
      void'(in_q.pop_front());
      pend_q.push_back(cyc);
      popc_q.push_back(cyc);
    end
    if (out_wr_en) begin
      got_q.push_back(int'(dout));
      if (exp_q.size() == 0) chk("push_without_pop", exp_q.size(), 1);
      else                   chk("sb_dout", dout, exp_q.pop_front());
      if (pend_q.size() != 0) lat_q.push_back(cyc - pend_q.pop_front());
    end
  endtask

  task automatic reset_dut();
    @(negedge clock);
    reset    = 1'b0;
    in_empty = 1'b0;
    real_in  = 1024;
    imag_in  = 0;
    out_full = 1'b0;
    in_q.delete(); exp_q.delete(); got_q.delete();
    lat_q.delete(); pend_q.delete(); popc_q.delete();
    prv_re = 0;
    prv_im = 0;
    #1;
    chk("rst_dout",   dout, 0);
    chk("rst_rd_en",  in_rd_en, 0);
    chk("rst_wr_en",  out_wr_en, 0);
    repeat (2) @(negedge clock);
    in_empty = 1'b1;
    reset    = 1'b1;
  endtask

  task automatic feed(input int re, input int im);
    samp_t s;
    s.re = re;
    s.im = im;
    in_q.push_back(s);
  endtask

  task automatic drain(input int n, input int budget);
    int target;
    target = got_q.size() + n;
    for (int k = 0; k < budget && got_q.size() < target; k++) cycle();
    chk("drain_count", got_q.size(), target);
  endtask

  initial begin
    reset    = 1'b0;
    in_empty = 1'b1;
    out_full = 1'b0;
    real_in  = 0;
    imag_in  = 0;

    // T1: first sample after reset, steady stream, latency and throughput
    reset_dut();
    feed(1024, 0);
    feed(1024, 0);
    drain(2, 200);
    chk("t1_first",  got_q[0], 1190);
    chk("t1_second", got_q[1], 1);
    chk("t1_latency", lat_q[0], 36);
    chk("t1_period", popc_q[1] - popc_q[0], 37);
    repeat (60) cycle();
    chk("t1_push_total", got_q.size(), 2);

    // T2: +90 and -90 degree steps
    reset_dut();
    feed(1024, 0);
    feed(0, 1024);
    drain(2, 200);
    chk("t2_pos", got_q[1], 1190);
    reset_dut();
    feed(1024, 0);
    feed(0, -1024);
    drain(2, 200);
    chk("t2_neg", got_q[1], -1190);

    // T3: 180 degree step takes the QUAD3 branch
    reset_dut();
    feed(1024, 0);
    feed(-1024, 0);
    drain(2, 200);
    chk("t3_quad3", got_q[1], 2379);

    // T4: output backpressure holds the result and blocks further pops
    reset_dut();
    full_mode = 1;
    feed(1024, 0);
    feed(1024, 0);
    for (int k = 0; k < 100 && dout !== 32'sd1190; k++) cycle();
    chk("t4_reach", dout, 1190);
    for (int k = 0; k < 100; k++) begin
      cycle();
      chk("t4_hold_wr", s_wr, 0);
      chk("t4_hold_rd", s_rd, 0);
      chk("t4_hold_dout", dout, 1190);
    end
    chk("t4_fifo_kept", in_q.size(), 1);
    full_mode = 0;
    cycle();
    chk("t4_release_push", s_wr, 1);
    chk("t4_release_cnt", got_q.size(), 1);
    drain(1, 200);
    chk("t4_next", got_q[1], 1);

    // T5: random samples with input gaps and output backpressure
    reset_dut();
    gap_mode  = 1'b1;
    full_mode = 2;
    for (int n = 0; n < 100; n++)
      feed(int'($urandom_range(0, 8192)) - 4096, int'($urandom_range(0, 8192)) - 4096);
    drain(100, 20000);
    chk("t5_sb_empty", exp_q.size(), 0);
    chk("t5_in_empty", in_q.size(), 0);
    gap_mode  = 1'b0;
    full_mode = 0;

    // T6: reset while the divider is running discards the sample
    reset_dut();
    feed(0, 1024);
    drain(1, 200);
    chk("t6_pre", got_q[0], 1190);
    feed(1024, 0);
    for (int k = 0; k < 50 && popc_q.size() < 2; k++) cycle();
    chk("t6_popped", popc_q.size(), 2);
    repeat (10) cycle();
    #2;
    reset = 1'b0;
    #1;
    chk("t6_dout_zero", dout, 0);
    chk("t6_rd_zero",   in_rd_en, 0);
    chk("t6_wr_zero",   out_wr_en, 0);
    exp_q.delete();
    pend_q.delete();
    prv_re = 0;
    prv_im = 0;
    repeat (3) cycle();
    reset = 1'b1;
    feed(1024, 0);
    drain(1, 200);
    chk("t6_first_again", got_q[got_q.size() - 1], 1190);
    chk("t6_push_total", got_q.size(), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
